// File: rtl/rc4_pkg.sv
// rc4_pkg: shared widths and KSA state encoding for the RC4 key scheduler and decrypter
package rc4_pkg;
    localparam int DATA_WIDTH  = 8;
    localparam int ADDR_WIDTH  = 8;
    localparam int KEY_BYTES   = 3;
    localparam int MESSAGE_LEN = 32;
    typedef enum logic [3:0] {
        IDLE, INIT, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE
    } ksa_state_t;
endpackage

// File: rtl/key_scheduler_if.sv
// key_scheduler_if: start/key request, scratch RAM port and finish flag of the key scheduler
interface key_scheduler_if;
    import rc4_pkg::*;
    logic                            start;
    logic [KEY_BYTES*DATA_WIDTH-1:0] key;
    logic [ADDR_WIDTH-1:0]           s_addr;
    logic [DATA_WIDTH-1:0]           s_data;
    logic                            s_wren;
    logic [DATA_WIDTH-1:0]           s_q;
    logic                            finish;
    modport master(input start, key, s_q, output s_addr, s_data, s_wren, finish);
    modport slave(output start, key, s_q, input s_addr, s_data, s_wren, finish);
endinterface

// File: rtl/key_scheduler.sv
// key_scheduler: fills scratch RAM with the identity permutation, then runs the RC4 KSA swap loop
module key_scheduler
    import rc4_pkg::*;
(
    input logic           clk,
    input logic           rst,
    key_scheduler_if.master bus
);
    ksa_state_t                      state, state_n;
    logic [ADDR_WIDTH-1:0]           i, j;
    logic [DATA_WIDTH-1:0]           si, sj, kb;
    logic [KEY_BYTES*DATA_WIDTH-1:0] key_r;
    logic [1:0]                      kidx;
    logic                            i_last;

    assign i_last = i == '1;
    assign kb = kidx == 2'd0 ? key_r[23:16] : kidx == 2'd1 ? key_r[15:8] : key_r[7:0];

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? INIT : IDLE;
            INIT:    state_n = i_last ? RD_I : INIT;
            RD_I:    state_n = WAIT_I;
            WAIT_I:  state_n = RD_J;
            RD_J:    state_n = WAIT_J;
            WAIT_J:  state_n = WR_I;
            WR_I:    state_n = WR_J;
            WR_J:    state_n = i_last ? DONE : RD_I;
            DONE:    state_n = bus.start ? DONE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address/data are pure decodes of state and counters, so RAM sees one access per cycle
    assign bus.s_addr = (state == RD_J || state == WR_J) ? j
                      : (state == INIT || state == RD_I || state == WR_I) ? i : '0;
    assign bus.s_data = state == INIT ? i : state == WR_I ? sj : state == WR_J ? si : '0;
    assign bus.s_wren = state == INIT || state == WR_I || state == WR_J;
    assign bus.finish = state == DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            key_r <= '0;
            kidx  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    key_r <= bus.key;
                    i     <= '0;
                    kidx  <= '0;
                end
                INIT: begin
                    i <= i + 1'b1;
                    if (i_last) begin
                        j    <= '0;
                        kidx <= '0;
                    end
                end
                WAIT_I: begin
                    si <= bus.s_q;
                    j  <= j + bus.s_q + kb;
                end
                WAIT_J: sj <= bus.s_q;
                WR_J: if (!i_last) begin
                    i    <= i + 1'b1;
                    kidx <= kidx == 2'd2 ? 2'd0 : kidx + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_key_scheduler.sv
// tb_key_scheduler: drives KSA runs against a write-first scratch RAM and a software RC4 KSA model
module tb_key_scheduler;
    logic clk, rst;
    int total = 0, bad = 0;
    logic [7:0] mem [256];
    int ref_s [256];

    key_scheduler_if bus();
    key_scheduler dut(.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.s_wren) mem[bus.s_addr] <= bus.s_data;
        bus.s_q <= bus.s_wren ? bus.s_data : mem[bus.s_addr];
    end

    typedef struct {
        logic [23:0] key;
        logic [23:0] alt_key;
        int          alt_edge;
        int          drop_edge;
        int          hold;
    } vec_t;
    vec_t v [6];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model(input logic [23:0] k);
        int kb [3];
        int j, t;
        kb[0] = int'(k[23:16]);
        kb[1] = int'(k[15:8]);
        kb[2] = int'(k[7:0]);
        for (int n = 0; n < 256; n++) ref_s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + ref_s[n] + kb[n % 3]) % 256;
            t = ref_s[n];
            ref_s[n] = ref_s[j];
            ref_s[j] = t;
        end
    endtask

    task automatic check_ram(input string nm, input logic [23:0] k);
        int nbad = 0;
        model(k);
        for (int n = 0; n < 256; n++) if (int'(mem[n]) != ref_s[n]) nbad++;
        check(nm, nbad, 0);
    endtask

    task automatic run(input logic [23:0] k, input logic [23:0] alt_k, input int alt_edge,
                       input int drop_edge, input int hold, input int early);
        int fin = -1;
        int init_bad = 0;
        int idn_bad = 0;
        int writes = 0;
        int lost = 0;
        @(negedge clk);
        bus.key = k;
        bus.start = 1'b1;
        for (int n = 0; n < 2000 && fin < 0; n++) begin
            @(posedge clk);
            #1;
            if (n == alt_edge) bus.key = alt_k;
            if (n == drop_edge) bus.start = 1'b0;
            if (n < 256 && !(bus.s_wren && int'(bus.s_addr) == n)) init_bad++;
            if (early && n == 256) begin
                for (int m = 0; m < 256; m++) if (int'(mem[m]) != m) idn_bad++;
                check("identity_fill", idn_bad, 0);
                check("ksa_read_no_write", int'(bus.s_wren), 0);
            end
            if (early && n == 274) begin
                check("self_swap_s0", int'(mem[0]), 0);
                check("self_swap_s1", int'(mem[1]), 1);
                check("swap_s2", int'(mem[2]), 3);
                check("swap_s3", int'(mem[3]), 2);
            end
            if (bus.finish) fin = n;
        end
        check("finish_edge", fin, 1792);
        check("init_sequence", init_bad, 0);
        check_ram("final_ram", k);
        if (hold) begin
            repeat (50) begin
                @(posedge clk);
                #1;
                if (!bus.finish) lost++;
                if (bus.s_wren) writes++;
            end
            check("finish_held", lost, 0);
            check("no_writes_in_done", writes, 0);
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("finish_drop", int'(bus.finish), 0);
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0;
        bus.key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", int'(bus.s_addr), 0);
        check("rst_data", int'(bus.s_data), 0);
        check("rst_wren", int'(bus.s_wren), 0);
        check("rst_finish", int'(bus.finish), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run(24'h000000, 24'h000000, -1, -1, 0, 1);

        v[0] = '{24'h00033C, 24'h00033C, -1, -1, 0};
        v[1] = '{24'h00033C, 24'hFFFFFF, 500, -1, 0};
        v[2] = '{24'h00033C, 24'h00033C, -1, -1, 1};
        v[3] = '{24'h00033C, 24'h00033C, -1, -1, 0};
        for (int n = 4; n < 6; n++)
            v[n] = '{24'($urandom), 24'($urandom), int'($urandom_range(1, 1700)),
                     int'($urandom_range(1, 1791)), 0};
        for (int n = 0; n < 6; n++)
            run(v[n].key, v[n].alt_key, v[n].alt_edge, v[n].drop_edge, v[n].hold, 0);

        @(negedge clk);
        bus.key = 24'h00033C;
        bus.start = 1'b1;
        repeat (901) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_wren", int'(bus.s_wren), 0);
        check("midrst_finish", int'(bus.finish), 0);
        check("midrst_addr", int'(bus.s_addr), 0);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        run(24'h00033C, 24'h00033C, -1, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_scheduler.md
Name: key_scheduler

Overview:
- RC4 key-scheduling stage that sits directly upstream of the decrypter.
- Fills the shared 256-byte scratch RAM with the identity permutation (s[i]=i).
- Then runs the KSA swap loop with a 24-bit secret key.
- Raises finish when the scratch RAM holds the scheduled state the decrypter consumes.

Parameters:
- DATA_WIDTH, 8, scratch RAM word width.
- ADDR_WIDTH, 8, scratch RAM address width (256 entries).
- KEY_BYTES, 3, key length in bytes.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level request to begin scheduling
- key  in  24  secret key; key[23:16]=byte0, key[15:8]=byte1, key[7:0]=byte2
- s_addr  out  8  scratch RAM address
- s_data  out  8  scratch RAM write data
- s_wren  out  1  scratch RAM write enable
- s_q  in  8  scratch RAM read data (synchronous, 1-cycle latency, write-first)
- finish  out  1  scheduling complete

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; i, j, si, sj, key_r cleared; s_addr=0, s_data=0, s_wren=0, finish=0.
- Outputs are Moore: decoded from registered state and counters only.
- IDLE: on a rising edge with start=1, latch key into key_r, set i=0, go to INIT.
  - key is ignored after latching; start deassertion mid-run is ignored.
- INIT: s_addr=i, s_data=i, s_wren=1 each cycle; i increments.
  - After the i=255 cycle, i wraps to 0, j=0, go to RD_I.
- KSA loop, 6 cycles per i, all sums mod 256:
  - RD_I: s_addr=i, s_wren=0.
  - WAIT_I: s_q now valid; latch si=s_q; latch j = j + s_q + key_r byte[i mod 3].
  - RD_J: s_addr=j.
  - WAIT_J: latch sj=s_q.
  - WR_I: s_addr=i, s_data=sj, s_wren=1.
  - WR_J: s_addr=j, s_data=si, s_wren=1. If i==255 go to DONE, else i++ and go to RD_I.
- i mod 3 uses a 2-bit key index counter that advances with i and wraps 2→0. No divider.
- i==j: the WR_I then WR_J ordering writes si twice; the result is correct and needs no special case.
- DONE: finish=1, s_wren=0.
  - Stays in DONE while start=1. No re-trigger.
  - On an edge with start=0, go to IDLE; finish=0 the following cycle.
- Latency: counting the edge that samples start as edge 0, finish=1 after edge 1792 (256 INIT + 256×6 KSA).
- Reset mid-operation: immediate return to the reset values above. RAM contents are then undefined; a new start fully re-initialises them.
- Exactly one RAM access per cycle; no read and write in the same cycle.

Decomposition:
- Shared package rc4_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, KEY_BYTES, MESSAGE_LEN constants.
  - ksa_state_t enum: IDLE, INIT, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE.
- The decrypter also uses rc4_pkg for its widths.
- No sub-module; key byte select is an inline 3-way mux on the key index counter.

Test Plan:
- Reset then start with key=24'h000000; inspect the bench scratch model after edge 256 -> scratch[k]=k for all k 0..255; s_wren high on edges 1..256 with s_addr=0..255 in order.
- key=24'h000000, observe first three iterations:
  - i=0 and i=1 give j=0 and j=1 (self-swaps); s[0]=0, s[1]=1 unchanged.
  - i=2 gives j=3; after that WR_J, s[2]=3 and s[3]=2.
- key=24'h00033C full run -> finish rises exactly after edge 1792; final scratch matches the software RC4 KSA golden file swapped.mem byte-for-byte.
- Change key to 24'hFFFFFF at edge 500 of a run with key=24'h00033C -> final scratch is identical to the unchanged-key golden.
- Drive rst=0 at edge 900 -> s_wren=0, finish=0 and s_addr=0 within the same cycle. Release rst, pulse start -> correct golden result and finish after 1792 edges.
- Hold start=1 for 50 cycles after finish -> finish stays 1, no RAM writes. Drop start -> finish=0 one edge later. Reassert start -> second complete run gives the same result.
